mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus between the I-cache miss path (fetch/decode stage) and the D-cache miss path (memory access stage).
- Grants the bus to one requester at a time and sequences a fixed-length block burst, word by word.
- Returns read data to the granted requester and signals completion.
- Sits between the two cache controllers and the memory interface.

---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: grants the shared bus to the I-cache or D-cache miss path and runs a fixed-length word burst.
// Optional macro VCPU32_ARB_RR_EN selects round-robin arbitration; by default D-side has fixed priority over I-side.
module mem_bus_arbiter #(
    parameter int WORD_LENGTH = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iReq,
    input  logic [WORD_LENGTH-1:0]         iAddr,
    output logic                           iGnt,
    output logic [WORD_LENGTH-1:0]         iRData,
    output logic                           iRValid,
    output logic                           iDone,
    input  logic                           dReq,
    input  logic                           dWr,
    input  logic [WORD_LENGTH-1:0]         dAddr,
    input  logic [WORD_LENGTH-1:0]         dWData,
    output logic                           dGnt,
    output logic [WORD_LENGTH-1:0]         dRData,
    output logic                           dRValid,
    output logic [$clog2(BLOCK_WORDS)-1:0] dWordIdx,
    output logic                           dDone,
    output logic                           memReq,
    output logic                           memWr,
    output logic [WORD_LENGTH-1:0]         memAddr,
    output logic [WORD_LENGTH-1:0]         memWData,
    input  logic [WORD_LENGTH-1:0]         memRData,
    input  logic                           memAck
);
    // state  | meaning
    // IDLE   | no owner; requests sampled here only
    // XFER_I | I-side owns the bus, burst in progress
    // XFER_D | D-side owns the bus, burst in progress
    // DONE   | one-cycle completion strobe to the owner

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]       LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [WORD_LENGTH-1:0] LOW_MASK  = WORD_LENGTH'((1 << (CNT_W + 2)) - 1);

    typedef enum logic [1:0] {IDLE, XFER_I, XFER_D, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   owner_d;
    logic                   wr;
    logic [WORD_LENGTH-1:0] base_addr;
    logic                   grant_d;
    logic                   grant_any;

`ifdef VCPU32_ARB_RR_EN
    logic last_owner_d;

    // On a tie, the side that did not own the last burst wins.
    assign grant_d = dReq && (!iReq || !last_owner_d);
`else
    assign grant_d = dReq;
`endif
    assign grant_any = dReq || iReq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            wr        <= 1'b0;
            base_addr <= '0;
`ifdef VCPU32_ARB_RR_EN
            last_owner_d <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && grant_any) begin
                owner_d   <= grant_d;
                wr        <= grant_d && dWr;
                base_addr <= (grant_d ? dAddr : iAddr) & ~LOW_MASK;
            end
`ifdef VCPU32_ARB_RR_EN
            if (state == DONE) begin
                last_owner_d <= owner_d;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        iGnt      = 1'b0;
        iRData    = '0;
        iRValid   = 1'b0;
        iDone     = 1'b0;
        dGnt      = 1'b0;
        dRData    = '0;
        dRValid   = 1'b0;
        dDone     = 1'b0;
        memReq    = 1'b0;
        memWr     = 1'b0;
        memAddr   = '0;
        memWData  = '0;
        dWordIdx  = cnt;

        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = grant_d ? XFER_D : XFER_I;
                end
            end
            XFER_I, XFER_D: begin
                iGnt    = (state == XFER_I);
                dGnt    = (state == XFER_D);
                memReq  = 1'b1;
                memWr   = wr;
                memAddr = base_addr + {{(WORD_LENGTH - CNT_W - 2){1'b0}}, cnt, 2'b00};
                if (state == XFER_D && wr) begin
                    memWData = dWData;
                end
                if (memAck) begin
                    if (!wr) begin
                        iRValid = (state == XFER_I);
                        dRValid = (state == XFER_D);
                        iRData  = (state == XFER_I) ? memRData : '0;
                        dRData  = (state == XFER_D) ? memRData : '0;
                    end
                    if (cnt == LAST_WORD) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                iGnt      = !owner_d;
                dGnt      = owner_d;
                iDone     = !owner_d;
                dDone     = owner_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (BLOCK_WORDS = 4, WORD_LENGTH = 32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iGnt;
    logic [31:0] iRData;
    logic        iRValid;
    logic        iDone;
    logic        dReq;
    logic        dWr;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic        dGnt;
    logic [31:0] dRData;
    logic        dRValid;
    logic [1:0]  dWordIdx;
    logic        dDone;
    logic        memReq;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.WORD_LENGTH(32), .BLOCK_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRData(iRData), .iRValid(iRValid), .iDone(iDone),
        .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWData(dWData), .dGnt(dGnt), .dRData(dRData),
        .dRValid(dRValid), .dWordIdx(dWordIdx), .dDone(dDone),
        .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .memAck(memAck)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; iReq = 0; iAddr = 0; dReq = 0; dWr = 0; dAddr = 0; dWData = 0;
        memRData = 0; memAck = 0;
        tick(); tick();
        checks++;
        if ({iGnt, dGnt, iDone, dDone, iRValid, dRValid, memReq, memWr} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000000",
                {iGnt, dGnt, iDone, dDone, iRValid, dRValid, memReq, memWr});
        end
        checks++;
        if ({memAddr, memWData, iRData, dRData, dWordIdx} !== 130'd0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h/%h/%h exp all zero",
                memAddr, memWData, iRData, dRData, dWordIdx);
        end
        rst = 1'b0;
    endtask

    task automatic test_i_read();
        iReq = 1'b1; iAddr = 32'h0000_1234;
        #1;
        checks++;
        if (iGnt !== 1'b0) begin errors++; $display("FAIL i_gnt_early got %b exp 0", iGnt); end
        tick();
        checks++;
        if ({iGnt, dGnt} !== 2'b10) begin errors++; $display("FAIL i_gnt_latency got %b exp 10", {iGnt, dGnt}); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({memReq, memWr, memAddr} !== {2'b10, 32'h1230 + 32'(4 * k)}) begin
                errors++; $display("FAIL i_addr%0d got %b%b %h exp 10 %h", k, memReq, memWr, memAddr, 32'h1230 + 32'(4 * k));
            end
            memAck = 1'b1; memRData = 32'hA0 + 32'(k);
            #1;
            checks++;
            if ({iRValid, dRValid, iDone, iRData, dRData} !== {3'b100, 32'hA0 + 32'(k), 32'h0}) begin
                errors++; $display("FAIL i_rdata%0d got %b%b%b %h %h exp 100 %h 0", k, iRValid, dRValid, iDone,
                    iRData, dRData, 32'hA0 + 32'(k));
            end
            tick();
            memAck = 1'b0;
        end
        #1;
        checks++;
        if ({iDone, iGnt, memReq, dDone, iRValid} !== 5'b11000) begin
            errors++; $display("FAIL i_done got %b exp 11000", {iDone, iGnt, memReq, dDone, iRValid});
        end
        iReq = 1'b0;
        tick();
        checks++;
        if ({iGnt, iDone, memReq} !== 3'b000) begin errors++; $display("FAIL i_idle got %b exp 000", {iGnt, iDone, memReq}); end
    endtask

    task automatic test_d_write();
        dReq = 1'b1; dWr = 1'b1; dAddr = 32'h0000_2000;
        tick();
        dWr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            memAck = 1'b0; dWData = 32'h100 + 32'(k);
            #1;
            checks++;
            if ({dGnt, memReq, memWr, dDone, dWordIdx} !== {4'b1110, 2'(k)}) begin
                errors++; $display("FAIL d_wr_ctrl%0d got %b%b%b%b %0d exp 1110 %0d", k, dGnt, memReq, memWr, dDone, dWordIdx, k);
            end
            checks++;
            if ({memAddr, memWData} !== {32'h2000 + 32'(4 * k), 32'h100 + 32'(k)}) begin
                errors++; $display("FAIL d_wr_bus%0d got %h %h exp %h %h", k, memAddr, memWData,
                    32'h2000 + 32'(4 * k), 32'h100 + 32'(k));
            end
            tick();
            memAck = 1'b1;
            #1;
            checks++;
            if ({dRValid, iRValid} !== 2'b00) begin errors++; $display("FAIL d_wr_rvalid%0d got %b exp 00", k, {dRValid, iRValid}); end
            tick();
            memAck = 1'b0;
        end
        #1;
        checks++;
        if ({dDone, dGnt, memReq, iDone} !== 4'b1100) begin
            errors++; $display("FAIL d_wr_done got %b exp 1100", {dDone, dGnt, memReq, iDone});
        end
        dReq = 1'b0;
        tick();
        checks++;
        if ({dGnt, dDone} !== 2'b00) begin errors++; $display("FAIL d_wr_idle got %b exp 00", {dGnt, dDone}); end
    endtask

    task automatic test_both_fixed();
        rst = 1'b1; tick(); rst = 1'b0;
        iReq = 1'b1; iAddr = 32'h4000; dReq = 1'b1; dWr = 1'b0; dAddr = 32'h5000;
        tick();
        checks++;
        if ({dGnt, iGnt, memAddr} !== {2'b10, 32'h5000}) begin
            errors++; $display("FAIL both_first got %b %h exp 10 5000", {dGnt, iGnt}, memAddr);
        end
        for (int k = 0; k < 4; k++) begin
            memAck = 1'b1; memRData = 32'hD0 + 32'(k);
            #1;
            checks++;
            if ({dRValid, iRValid, dRData, iRData} !== {2'b10, 32'hD0 + 32'(k), 32'h0}) begin
                errors++; $display("FAIL both_drd%0d got %b%b %h %h exp 10 %h 0", k, dRValid, iRValid, dRData, iRData, 32'hD0 + 32'(k));
            end
            tick();
        end
        memAck = 1'b0;
        #1;
        checks++;
        if ({dDone, iGnt} !== 2'b10) begin errors++; $display("FAIL both_ddone got %b exp 10", {dDone, iGnt}); end
        dReq = 1'b0;
        tick();
        checks++;
        if ({iGnt, dGnt} !== 2'b00) begin errors++; $display("FAIL both_gap got %b exp 00", {iGnt, dGnt}); end
        tick();
        checks++;
        if ({iGnt, memAddr} !== {1'b1, 32'h4000}) begin
            errors++; $display("FAIL both_i_after got %b %h exp 1 4000", iGnt, memAddr);
        end
        memAck = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        memAck = 1'b0;
        #1;
        checks++;
        if ({iDone, dDone} !== 2'b10) begin errors++; $display("FAIL both_idone got %b exp 10", {iDone, dDone}); end
        iReq = 1'b0;
        tick();
    endtask

    task automatic test_rr();
        logic [3:0] exp_d;
`ifdef VCPU32_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        iReq = 1'b1; iAddr = 32'h4000; dReq = 1'b1; dWr = 1'b0; dAddr = 32'h5000;
        for (int b = 0; b < 4; b++) begin
            tick();
            checks++;
            if ({dGnt, iGnt, memAddr} !== {exp_d[b], !exp_d[b], exp_d[b] ? 32'h5000 : 32'h4000}) begin
                errors++; $display("FAIL rr_gnt%0d got %b %h exp %b%b", b, {dGnt, iGnt}, memAddr, exp_d[b], !exp_d[b]);
            end
            memAck = 1'b1;
            for (int k = 0; k < 4; k++) tick();
            memAck = 1'b0;
            #1;
            checks++;
            if ({dDone, iDone} !== {exp_d[b], !exp_d[b]}) begin
                errors++; $display("FAIL rr_done%0d got %b exp %b%b", b, {dDone, iDone}, exp_d[b], !exp_d[b]);
            end
            tick();
        end
        iReq = 1'b0; dReq = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        iReq = 1'b1; iAddr = 32'h6018;
        tick();
        memAck = 1'b1;
        tick(); tick();
        memAck = 1'b0;
        #1;
        checks++;
        if ({iGnt, memAddr} !== {1'b1, 32'h6018}) begin
            errors++; $display("FAIL rst_mid_word2 got %b %h exp 1 6018", iGnt, memAddr);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({memReq, iGnt, iDone, dWordIdx} !== 5'b00000) begin
            errors++; $display("FAIL rst_mid_abort got %b%b%b %0d exp 000 0", memReq, iGnt, iDone, dWordIdx);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({iGnt, memAddr, dWordIdx} !== {1'b1, 32'h6010, 2'd0}) begin
            errors++; $display("FAIL rst_mid_restart got %b %h %0d exp 1 6010 0", iGnt, memAddr, dWordIdx);
        end
        memAck = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        memAck = 1'b0;
        #1;
        checks++;
        if (iDone !== 1'b1) begin errors++; $display("FAIL rst_mid_done got %b exp 1", iDone); end
        iReq = 1'b0;
        tick();
    endtask

    task automatic test_idle_ack_drop();
        memAck = 1'b1; memRData = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({iRValid, dRValid, memReq, iGnt, dGnt, iRData, dRData} !== 69'd0) begin
            errors++; $display("FAIL idle_ack got %b %h %h exp 0", {iRValid, dRValid, memReq, iGnt, dGnt}, iRData, dRData);
        end
        tick();
        memAck = 1'b0;
        #1;
        checks++;
        if ({iGnt, dGnt, dWordIdx} !== 4'b0000) begin
            errors++; $display("FAIL idle_ack_state got %b%b %0d exp 00 0", iGnt, dGnt, dWordIdx);
        end
        dReq = 1'b1; dWr = 1'b0; dAddr = 32'h300B;
        tick();
        dReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            memAck = 1'b1; memRData = 32'hC0 + 32'(k);
            #1;
            checks++;
            if ({dGnt, dRValid, memAddr, dRData} !== {2'b11, 32'h3000 + 32'(4 * k), 32'hC0 + 32'(k)}) begin
                errors++; $display("FAIL drop_word%0d got %b%b %h %h exp 11 %h %h", k, dGnt, dRValid, memAddr, dRData,
                    32'h3000 + 32'(4 * k), 32'hC0 + 32'(k));
            end
            tick();
        end
        memAck = 1'b0;
        #1;
        checks++;
        if ({dDone, dGnt} !== 2'b11) begin errors++; $display("FAIL drop_done got %b exp 11", {dDone, dGnt}); end
        tick();
        tick();
        checks++;
        if ({dGnt, iGnt, memReq} !== 3'b000) begin errors++; $display("FAIL drop_no_regrant got %b exp 000", {dGnt, iGnt, memReq}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_i_read();
        test_d_write();
        test_both_fixed();
        test_rr();
        test_reset_mid();
        test_idle_ack_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
